cache_port_arbiter: RTL and testbench



---
 rtl/cache_port_arbiter_pkg.sv | 28 ++
 rtl/cache_port_arbiter_tag_fifo.sv | 76 +++++++
 rtl/cache_port_arbiter.sv | 153 +++++++++++++++
 tb/tb_cache_port_arbiter.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_port_arbiter_pkg.sv
// cache_port_arbiter_pkg: shared widths, requester encodings and tag layout
// for the cache port arbiter and its tag queue.
// Optional build macro: ARB_ROUND_ROBIN_EN (see cache_port_arbiter.sv).
package cache_port_arbiter_pkg;

    localparam int ADDR_W            = 25;
    localparam int DATA_W            = 32;
    localparam int BE_W              = 4;
    localparam int MAX_OUTST_DEFAULT = 4;

    // Identifies which front-end issued a cache transaction.
    typedef enum logic {
        SRC_IF = 1'b0,
        SRC_LS = 1'b1
    } src_e;

    // One entry of the outstanding-read queue.
    typedef struct packed {
        src_e src;
        logic discard;
    } tag_t;

    // The requester that gets the next turn after 'who' was served.
    function automatic src_e other_src(input src_e who);
        return (who == SRC_IF) ? SRC_LS : SRC_IF;
    endfunction

endpackage

// File: rtl/cache_port_arbiter_tag_fifo.sv
// arb_tag_fifo: in-order queue of outstanding-read tags. Each entry carries
// the issuing requester and a discard bit. A bulk input marks every queued
// entry of a given requester as discard, so a front-end can abandon its
// in-flight reads without disturbing the return order.
module arb_tag_fifo
    import cache_port_arbiter_pkg::*;
#(
    parameter int DEPTH = MAX_OUTST_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  src_e push_src,
    input  logic pop,
    input  logic discard_set,
    input  src_e discard_src,
    output logic full,
    output logic empty,
    output tag_t head
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    src_e             src_q [DEPTH];
    logic [DEPTH-1:0] disc_q;
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == FULL_COUNT);
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    assign head.src     = src_q[rd_ptr];
    assign head.discard = disc_q[rd_ptr];

    // Queue storage and pointers; the bulk discard is applied before the push so a new entry always starts clean.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            disc_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                src_q[i] <= SRC_IF;
            end
        end else begin
            if (discard_set) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (src_q[i] == discard_src) begin
                        disc_q[i] <= 1'b1;
                    end
                end
            end
            if (do_push) begin
                src_q[wr_ptr]  <= push_src;
                disc_q[wr_ptr] <= 1'b0;
                wr_ptr         <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/cache_port_arbiter.sv
// cache_port_arbiter: shares one Avalon-style cache port between the fetch
// unit (IF) and the load/store unit (LS). Grant and waitrequest are purely
// combinational; returned read data is steered by an in-order tag queue.
// A fetch flush marks all queued fetch reads so their returns are dropped.
// Build macro ARB_ROUND_ROBIN_EN: when defined, a two-way round-robin pointer
// arbitrates ties; otherwise LS has fixed priority over IF.
module cache_port_arbiter
    import cache_port_arbiter_pkg::*;
#(
    parameter int MAX_OUTST = MAX_OUTST_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_read,
    output logic              if_waitrequest,
    output logic [DATA_W-1:0] if_readdata,
    output logic              if_readdata_valid,
    input  logic              if_flush,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [BE_W-1:0]   ls_byte_en,
    input  logic [DATA_W-1:0] ls_writedata,
    input  logic              ls_read,
    input  logic              ls_write,
    output logic              ls_waitrequest,
    output logic [DATA_W-1:0] ls_readdata,
    output logic              ls_readdata_valid,
    output logic [ADDR_W-1:0] m_addr,
    output logic [BE_W-1:0]   m_byte_en,
    output logic [DATA_W-1:0] m_writedata,
    output logic              m_read,
    output logic              m_write,
    input  logic [DATA_W-1:0] m_readdata,
    input  logic              m_readdata_valid,
    input  logic              m_waitrequest,
    output logic              err_orphan
);

    logic q_full;
    logic q_empty;
    tag_t q_head;
    logic if_elig;
    logic ls_elig;
    logic grant_if;
    logic grant_ls;
    logic accept;
    logic q_push;
    src_e q_push_src;
    logic rsp_pop;

`ifdef ARB_ROUND_ROBIN_EN
    src_e rr_ptr;
`endif

    // Reads need a free queue slot; fetch is also held off while it flushes.
    assign if_elig = if_read & ~if_flush & ~q_full;
    assign ls_elig = ls_write | (ls_read & ~q_full);

    // Pick at most one winner among the eligible requesters; nobody wins in reset.
    always_comb begin
        grant_if = 1'b0;
        grant_ls = 1'b0;
        if (!rst) begin
`ifdef ARB_ROUND_ROBIN_EN
            if (if_elig && ls_elig) begin
                if (rr_ptr == SRC_LS) begin
                    grant_ls = 1'b1;
                end else begin
                    grant_if = 1'b1;
                end
            end else begin
                grant_if = if_elig;
                grant_ls = ls_elig;
            end
`else
            grant_ls = ls_elig;
            grant_if = if_elig & ~ls_elig;
`endif
        end
    end

    // Drive the cache request from the winner, or all zeros when idle.
    always_comb begin
        m_addr      = '0;
        m_byte_en   = '0;
        m_writedata = '0;
        m_read      = 1'b0;
        m_write     = 1'b0;
        if (grant_ls) begin
            m_addr      = ls_addr;
            m_byte_en   = ls_byte_en;
            m_writedata = ls_writedata;
            m_read      = ls_read;
            m_write     = ls_write;
        end else if (grant_if) begin
            m_addr      = if_addr;
            m_byte_en   = '1;
            m_writedata = '0;
            m_read      = 1'b1;
            m_write     = 1'b0;
        end
    end

    assign accept         = (grant_if | grant_ls) & ~m_waitrequest;
    assign if_waitrequest = grant_if ? m_waitrequest : 1'b1;
    assign ls_waitrequest = grant_ls ? m_waitrequest : 1'b1;

    assign q_push     = accept & (grant_if | (grant_ls & ls_read));
    assign q_push_src = grant_ls ? SRC_LS : SRC_IF;

    // A return consumes the head tag; a flush in the same cycle also kills a fetch return.
    assign rsp_pop           = m_readdata_valid & ~q_empty & ~rst;
    assign ls_readdata_valid = rsp_pop & (q_head.src == SRC_LS);
    assign if_readdata_valid = rsp_pop & (q_head.src == SRC_IF) & ~q_head.discard & ~if_flush;
    assign if_readdata       = m_readdata;
    assign ls_readdata       = m_readdata;

    arb_tag_fifo #(
        .DEPTH(MAX_OUTST)
    ) u_tag_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (q_push),
        .push_src   (q_push_src),
        .pop        (rsp_pop),
        .discard_set(if_flush & ~rst),
        .discard_src(SRC_IF),
        .full       (q_full),
        .empty      (q_empty),
        .head       (q_head)
    );

    // Sticky flag for a return that had no outstanding read to match.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_orphan <= 1'b0;
        end else if (m_readdata_valid && q_empty) begin
            err_orphan <= 1'b1;
        end
    end

`ifdef ARB_ROUND_ROBIN_EN
    // Hand the next tie to the requester that was not just served.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= SRC_IF;
        end else if (accept) begin
            rr_ptr <= other_src(grant_ls ? SRC_LS : SRC_IF);
        end
    end
`endif

endmodule

// File: tb/tb_cache_port_arbiter.sv
// tb_cache_port_arbiter: directed self-checking bench for cache_port_arbiter
// with MAX_OUTST = 4. Expectations follow ARB_ROUND_ROBIN_EN when defined.
module tb_cache_port_arbiter;

    logic        clk;
    logic        rst;
    logic [24:0] if_addr;
    logic        if_read;
    logic        if_waitrequest;
    logic [31:0] if_readdata;
    logic        if_readdata_valid;
    logic        if_flush;
    logic [24:0] ls_addr;
    logic [3:0]  ls_byte_en;
    logic [31:0] ls_writedata;
    logic        ls_read;
    logic        ls_write;
    logic        ls_waitrequest;
    logic [31:0] ls_readdata;
    logic        ls_readdata_valid;
    logic [24:0] m_addr;
    logic [3:0]  m_byte_en;
    logic [31:0] m_writedata;
    logic        m_read;
    logic        m_write;
    logic [31:0] m_readdata;
    logic        m_readdata_valid;
    logic        m_waitrequest;
    logic        err_orphan;

    int checks;
    int failures;

    cache_port_arbiter #(
        .MAX_OUTST(4)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .if_addr          (if_addr),
        .if_read          (if_read),
        .if_waitrequest   (if_waitrequest),
        .if_readdata      (if_readdata),
        .if_readdata_valid(if_readdata_valid),
        .if_flush         (if_flush),
        .ls_addr          (ls_addr),
        .ls_byte_en       (ls_byte_en),
        .ls_writedata     (ls_writedata),
        .ls_read          (ls_read),
        .ls_write         (ls_write),
        .ls_waitrequest   (ls_waitrequest),
        .ls_readdata      (ls_readdata),
        .ls_readdata_valid(ls_readdata_valid),
        .m_addr           (m_addr),
        .m_byte_en        (m_byte_en),
        .m_writedata      (m_writedata),
        .m_read           (m_read),
        .m_write          (m_write),
        .m_readdata       (m_readdata),
        .m_readdata_valid (m_readdata_valid),
        .m_waitrequest    (m_waitrequest),
        .err_orphan       (err_orphan)
    );

    // Free-running clock, 10 time units per cycle.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Inputs change 1 unit after a rising edge; checks run 2 units later.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_requests();
        if_read          = 1'b0;
        if_flush         = 1'b0;
        ls_read          = 1'b0;
        ls_write         = 1'b0;
        m_readdata_valid = 1'b0;
        m_waitrequest    = 1'b0;
    endtask

    // Directed sequence of scenarios.
    initial begin
        logic        exp_ls;
        logic [24:0] exp_addr;

        checks       = 0;
        failures     = 0;
        rst          = 1'b1;
        if_addr      = '0;
        ls_addr      = '0;
        ls_byte_en   = '0;
        ls_writedata = '0;
        m_readdata   = '0;
        clear_requests();

        // Reset: requests and returns must be ignored while rst is high.
        if_read          = 1'b1;
        m_readdata_valid = 1'b1;
        next_cycle();
        #2;
        check_output("rst_if_wait", if_waitrequest, 1'b1);
        check_output("rst_ls_wait", ls_waitrequest, 1'b1);
        check_output("rst_m_read", m_read, 1'b0);
        check_output("rst_m_write", m_write, 1'b0);
        check_output("rst_if_rdv", if_readdata_valid, 1'b0);
        check_output("rst_orphan", err_orphan, 1'b0);
        next_cycle();

        // Fetch read held off by the cache: request visible, not accepted.
        rst           = 1'b0;
        clear_requests();
        if_read       = 1'b1;
        if_addr       = 25'h0FF;
        m_waitrequest = 1'b1;
        #2;
        check_output("stall_m_read", m_read, 1'b1);
        check_output("stall_m_addr", m_addr, 32'h0FF);
        check_output("stall_if_wait", if_waitrequest, 1'b1);
        next_cycle();

        // Fetch-only burst of four reads.
        m_waitrequest = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if_addr = 25'h100 + 25'(i);
            #2;
            check_output("fetch_m_read", m_read, 1'b1);
            check_output("fetch_m_addr", m_addr, 32'h100 + 32'(i));
            check_output("fetch_m_be", m_byte_en, 4'hF);
            check_output("fetch_m_wdata", m_writedata, 32'h0);
            check_output("fetch_if_wait", if_waitrequest, 1'b0);
            check_output("fetch_ls_wait", ls_waitrequest, 1'b1);
            next_cycle();
        end

        // Queue full: fifth read stalls, an LS write still goes through.
        if_addr      = 25'h104;
        ls_write     = 1'b1;
        ls_addr      = 25'h050;
        ls_byte_en   = 4'h3;
        ls_writedata = 32'hDEADBEEF;
        #2;
        check_output("full_if_wait", if_waitrequest, 1'b1);
        check_output("full_m_read", m_read, 1'b0);
        check_output("full_m_write", m_write, 1'b1);
        check_output("full_ls_wait", ls_waitrequest, 1'b0);
        check_output("full_m_addr", m_addr, 32'h050);
        check_output("full_m_be", m_byte_en, 4'h3);
        check_output("full_m_wdata", m_writedata, 32'hDEADBEEF);
        next_cycle();

        // Drain the four fetch returns.
        clear_requests();
        for (int i = 0; i < 4; i++) begin
            m_readdata_valid = 1'b1;
            m_readdata       = 32'hA0 + 32'(i);
            #2;
            check_output("fret_if_rdv", if_readdata_valid, 1'b1);
            check_output("fret_ls_rdv", ls_readdata_valid, 1'b0);
            check_output("fret_if_data", if_readdata, 32'hA0 + 32'(i));
            next_cycle();
        end

        // Idle port drives zeros.
        clear_requests();
        #2;
        check_output("idle_m_read", m_read, 1'b0);
        check_output("idle_m_addr", m_addr, 32'h0);
        check_output("idle_m_be", m_byte_en, 4'h0);
        check_output("idle_orphan", err_orphan, 1'b0);
        next_cycle();

        // Contention: both request reads for four cycles.
        for (int i = 0; i < 4; i++) begin
            if_read    = 1'b1;
            if_addr    = 25'h110 + 25'(i);
            ls_read    = 1'b1;
            ls_addr    = 25'h400 + 25'(i);
            ls_byte_en = 4'hF;
`ifdef ARB_ROUND_ROBIN_EN
            exp_ls = (i % 2) == 1;
`else
            exp_ls = 1'b1;
`endif
            exp_addr = exp_ls ? (25'h400 + 25'(i)) : (25'h110 + 25'(i));
            #2;
            check_output("cont_m_addr", m_addr, 32'(exp_addr));
            check_output("cont_ls_wait", ls_waitrequest, !exp_ls);
            check_output("cont_if_wait", if_waitrequest, exp_ls);
            next_cycle();
        end

        // Contention returns go back in grant order.
        clear_requests();
        for (int i = 0; i < 4; i++) begin
`ifdef ARB_ROUND_ROBIN_EN
            exp_ls = (i % 2) == 1;
`else
            exp_ls = 1'b1;
`endif
            m_readdata_valid = 1'b1;
            m_readdata       = 32'hB0 + 32'(i);
            #2;
            check_output("cret_ls_rdv", ls_readdata_valid, exp_ls);
            check_output("cret_if_rdv", if_readdata_valid, !exp_ls);
            next_cycle();
        end

        // Flush: three fetch reads in flight, then flush plus an LS read.
        clear_requests();
        for (int i = 0; i < 3; i++) begin
            if_read = 1'b1;
            if_addr = 25'h200 + 25'(i);
            #2;
            check_output("fl_if_wait", if_waitrequest, 1'b0);
            next_cycle();
        end
        if_flush = 1'b1;
        if_read  = 1'b1;
        ls_read  = 1'b1;
        ls_addr  = 25'h300;
        #2;
        check_output("fl_blk_if_wait", if_waitrequest, 1'b1);
        check_output("fl_ls_wait", ls_waitrequest, 1'b0);
        check_output("fl_m_addr", m_addr, 32'h300);
        check_output("fl_m_read", m_read, 1'b1);
        next_cycle();
        clear_requests();
        for (int i = 0; i < 4; i++) begin
            m_readdata_valid = 1'b1;
            m_readdata       = 32'hC0 + 32'(i);
            #2;
            check_output("flret_if_rdv", if_readdata_valid, 1'b0);
            check_output("flret_ls_rdv", ls_readdata_valid, i == 3);
            if (i == 3) begin
                check_output("flret_ls_data", ls_readdata, 32'hC3);
            end
            next_cycle();
        end

        // A flush in the same cycle as a fetch return drops that return.
        clear_requests();
        if_read = 1'b1;
        if_addr = 25'h210;
        next_cycle();
        clear_requests();
        if_flush         = 1'b1;
        m_readdata_valid = 1'b1;
        m_readdata       = 32'hD0;
        #2;
        check_output("flsame_if_rdv", if_readdata_valid, 1'b0);
        check_output("flsame_ls_rdv", ls_readdata_valid, 1'b0);
        next_cycle();
        clear_requests();
        #2;
        check_output("flsame_orphan", err_orphan, 1'b0);
        next_cycle();

        // Orphan return on an empty queue; flag is sticky.
        m_readdata_valid = 1'b1;
        m_readdata       = 32'hE0;
        #2;
        check_output("orph_if_rdv", if_readdata_valid, 1'b0);
        check_output("orph_ls_rdv", ls_readdata_valid, 1'b0);
        next_cycle();
        clear_requests();
        #2;
        check_output("orph_set", err_orphan, 1'b1);
        next_cycle();
        #2;
        check_output("orph_sticky", err_orphan, 1'b1);
        next_cycle();

        // Reset with two reads outstanding.
        for (int i = 0; i < 2; i++) begin
            if_read = 1'b1;
            if_addr = 25'h220 + 25'(i);
            next_cycle();
        end
        rst = 1'b1;
        #2;
        check_output("mrst_if_wait", if_waitrequest, 1'b1);
        check_output("mrst_ls_wait", ls_waitrequest, 1'b1);
        check_output("mrst_m_read", m_read, 1'b0);
        next_cycle();
        rst     = 1'b0;
        if_addr = 25'h500;
        #2;
        check_output("mrst_orphan_clr", err_orphan, 1'b0);
        check_output("mrst_m_read2", m_read, 1'b1);
        check_output("mrst_if_wait2", if_waitrequest, 1'b0);
        next_cycle();
        clear_requests();
        m_readdata_valid = 1'b1;
        m_readdata       = 32'hF0;
        #2;
        check_output("mrst_ret_rdv", if_readdata_valid, 1'b1);
        check_output("mrst_ret_data", if_readdata, 32'hF0);
        next_cycle();
        m_readdata_valid = 1'b1;
        #2;
        check_output("mrst_extra_rdv", if_readdata_valid, 1'b0);
        check_output("mrst_no_orphan_yet", err_orphan, 1'b0);
        next_cycle();
        clear_requests();
        #2;
        check_output("mrst_queue_empty", err_orphan, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
